// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: boot, fetch, decode, execute and commit,
// with ALU and memory handshakes, an ALU watchdog and return-stack depth tracking.
module seq_control_unit #(
  parameter int OPW         = 6,
  parameter int STACK_DEPTH = 8,
  parameter int ALU_TIMEOUT = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_done_i,
  input  logic           instr_valid_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic           register_i,
  input  logic [3:0]     flags_i,
  input  logic           alu_done_i,
  input  logic           mem_ready_i,
  output logic           read_file_o,
  output logic           read_memory_o,
  output logic           start_alu_operation_o,
  output logic [2:0]     reg_signal_o,
  output logic           mem_read_o,
  output logic           mem_write_o,
  output logic           lda_signal_o,
  output logic           sta_signal_o,
  output logic           increm_pc_o,
  output logic           jump_o,
  output logic           push_o,
  output logic           pop_o,
  output logic           halted_o,
  output logic [1:0]     fault_o,
  output logic [3:0]     state_o
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int WW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [3:0] {
    ST_BOOT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_ALU_START = 4'd3,
    ST_ALU_WAIT  = 4'd4,
    ST_MEM_ACC   = 4'd5,
    ST_BRANCH    = 4'd6,
    ST_COMMIT    = 4'd7,
    ST_HALT      = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'b00,
    FLT_ILLEGAL = 2'b01,
    FLT_STACK   = 2'b10,
    FLT_ALU     = 2'b11
  } fault_e;

  typedef struct packed {
    logic       read_file;
    logic       read_memory;
    logic       start_alu;
    logic [2:0] reg_sel;
    logic       mem_read;
    logic       mem_write;
    logic       lda;
    logic       sta;
    logic       inc_pc;
    logic       jump;
    logic       push;
    logic       pop;
    logic       halted;
  } out_t;

  localparam logic [5:0] OP_IDLE   = 6'h00;
  localparam logic [5:0] OP_LDR    = 6'h01;
  localparam logic [5:0] OP_STR    = 6'h02;
  localparam logic [5:0] OP_STA    = 6'h03;
  localparam logic [5:0] OP_LDA    = 6'h04;
  localparam logic [5:0] OP_BRZ    = 6'h05;
  localparam logic [5:0] OP_BRN    = 6'h06;
  localparam logic [5:0] OP_BRC    = 6'h07;
  localparam logic [5:0] OP_BRO    = 6'h08;
  localparam logic [5:0] OP_JMP    = 6'h0A;
  localparam logic [5:0] OP_RET    = 6'h0B;
  localparam logic [5:0] OP_ALU_LO = 6'h0C;
  localparam logic [5:0] OP_ALU_HI = 6'h1D;

  state_e         state_q, state_d;
  fault_e         fault_q, fault_d;
  logic [OPW-1:0] opc_q, opc_d;
  logic           reg_q, reg_d;
  logic           taken_q, taken_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  out_t           out_q;

  logic [5:0] op6;
  logic       op_hi_zero;

  assign op6        = opc_q[5:0];
  assign op_hi_zero = ((opc_q >> 6) == '0);

  // JMP into a full stack or RET from an empty one is a stack fault.
  function automatic logic stack_fault(logic [5:0] op, logic [CW-1:0] cnt);
    return ((op == OP_JMP) && (cnt == CW'(STACK_DEPTH))) ||
           ((op == OP_RET) && (cnt == '0));
  endfunction

  function automatic logic branch_taken(logic [5:0] op, logic [3:0] fl);
    case (op)
      OP_BRZ:  return fl[3];
      OP_BRN:  return fl[1];
      OP_BRC:  return fl[0];
      OP_BRO:  return fl[2];
      default: return 1'b1;
    endcase
  endfunction

  function automatic out_t decode_outputs(state_e st, logic [5:0] op, logic rg, logic tk,
                                          logic stk_err);
    out_t       o;
    logic [2:0] xy;
    o  = '0;
    xy = rg ? 3'b100 : 3'b010;
    case (st)
      ST_BOOT:      o.read_file   = 1'b1;
      ST_FETCH:     o.read_memory = 1'b1;
      ST_ALU_START: begin
        o.start_alu = 1'b1;
        o.reg_sel   = xy;
      end
      ST_ALU_WAIT:  o.reg_sel = xy;
      ST_MEM_ACC: begin
        case (op)
          OP_LDR: begin o.mem_read  = 1'b1; o.reg_sel = xy; end
          OP_STR: begin o.mem_write = 1'b1; o.reg_sel = xy; end
          OP_LDA: begin o.mem_read  = 1'b1; o.lda = 1'b1; o.reg_sel = 3'b001; end
          OP_STA: begin o.mem_write = 1'b1; o.sta = 1'b1; o.reg_sel = 3'b001; end
          default: o = '0;
        endcase
      end
      ST_BRANCH: begin
        if (!stk_err) begin
          o.jump   = tk;
          o.inc_pc = !tk;
          o.push   = (op == OP_JMP);
          o.pop    = (op == OP_RET);
        end
      end
      ST_COMMIT:    o.inc_pc = 1'b1;
      ST_HALT:      o.halted = 1'b1;
      default:      o = '0;
    endcase
    return o;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    fault_d = fault_q;
    opc_d   = opc_q;
    reg_d   = reg_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      ST_BOOT: if (load_done_i) state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid_i) begin
          opc_d   = opcode_i;
          reg_d   = register_i;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_hi_zero) begin
          state_d = ST_HALT;
          fault_d = FLT_ILLEGAL;
        end else if (op6 >= OP_ALU_LO && op6 <= OP_ALU_HI) begin
          state_d = ST_ALU_START;
        end else if (op6 >= OP_LDR && op6 <= OP_LDA) begin
          state_d = ST_MEM_ACC;
        end else if (op6 >= OP_BRZ && op6 <= OP_RET) begin
          state_d = ST_BRANCH;
          taken_d = branch_taken(op6, flags_i);
        end else if (op6 == OP_IDLE) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_HALT;
          fault_d = FLT_ILLEGAL;
        end
      end
      ST_ALU_START: begin
        state_d = ST_ALU_WAIT;
        wdog_d  = '0;
      end
      ST_ALU_WAIT: begin
        // A completion arriving on the final permitted cycle still beats the watchdog.
        if (alu_done_i) begin
          state_d = ST_COMMIT;
        end else if (wdog_q == WW'(ALU_TIMEOUT - 1)) begin
          state_d = ST_HALT;
          fault_d = FLT_ALU;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_MEM_ACC: if (mem_ready_i) state_d = ST_COMMIT;
      ST_BRANCH: begin
        if (stack_fault(op6, cnt_q)) begin
          state_d = ST_HALT;
          fault_d = FLT_STACK;
        end else begin
          state_d = ST_FETCH;
          if (op6 == OP_JMP) cnt_d = cnt_q + CW'(1);
          if (op6 == OP_RET) cnt_d = cnt_q - CW'(1);
        end
      end
      ST_COMMIT: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q <= ST_BOOT;
      fault_q <= FLT_NONE;
      opc_q   <= '0;
      reg_q   <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= '0;
      out_q   <= decode_outputs(ST_BOOT, OP_IDLE, 1'b0, 1'b0, 1'b0);
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      opc_q   <= opc_d;
      reg_q   <= reg_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      out_q   <= decode_outputs(state_d, opc_d[5:0], reg_d, taken_d,
                                stack_fault(opc_d[5:0], cnt_d));
    end
  end

  assign read_file_o           = out_q.read_file;
  assign read_memory_o         = out_q.read_memory;
  assign start_alu_operation_o = out_q.start_alu;
  assign reg_signal_o          = out_q.reg_sel;
  assign mem_read_o            = out_q.mem_read;
  assign mem_write_o           = out_q.mem_write;
  assign lda_signal_o          = out_q.lda;
  assign sta_signal_o          = out_q.sta;
  assign increm_pc_o           = out_q.inc_pc;
  assign jump_o                = out_q.jump;
  assign push_o                = out_q.push;
  assign pop_o                 = out_q.pop;
  assign halted_o              = out_q.halted;
  assign fault_o               = fault_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit: a per-cycle vector table followed by
// hand-written watchdog sequences (STACK_DEPTH=2, ALU_TIMEOUT=16).
module tb_seq_control_unit;

  logic       clk = 1'b0;
  logic       rst, load_done, instr_valid, register, alu_done, mem_ready;
  logic [5:0] opcode;
  logic [3:0] flags;
  logic       read_file, read_memory, start_alu, mem_read, mem_write;
  logic       lda, sta, inc_pc, jump, push, pop, halted;
  logic [2:0] reg_signal;
  logic [1:0] fault;
  logic [3:0] state;

  always #5 clk = ~clk;

  seq_control_unit #(.OPW(6), .STACK_DEPTH(2), .ALU_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .load_done_i(load_done), .instr_valid_i(instr_valid),
    .opcode_i(opcode), .register_i(register), .flags_i(flags), .alu_done_i(alu_done),
    .mem_ready_i(mem_ready), .read_file_o(read_file), .read_memory_o(read_memory),
    .start_alu_operation_o(start_alu), .reg_signal_o(reg_signal), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .lda_signal_o(lda), .sta_signal_o(sta), .increm_pc_o(inc_pc),
    .jump_o(jump), .push_o(push), .pop_o(pop), .halted_o(halted), .fault_o(fault),
    .state_o(state)
  );

  localparam logic [3:0] BOOT = 4'd0, FETCH = 4'd1, DECODE = 4'd2, ASTART = 4'd3,
                         AWAIT = 4'd4, MEM = 4'd5, BRANCH = 4'd6, COMMIT = 4'd7, HALT = 4'd8;

  // Strobe bit positions: {read_file, read_memory, start, mem_read, mem_write,
  // lda, sta, inc_pc, jump, push, pop}.
  localparam logic [10:0] NO = 11'h000, RF = 11'h400, RM = 11'h200, SA = 11'h100,
                          MR = 11'h080, MW = 11'h040, LD = 11'h020, SS = 11'h010,
                          IP = 11'h008, JP = 11'h004, PU = 11'h002, PO = 11'h001;

  typedef struct packed {
    logic [3:0]  st;
    logic        hlt;
    logic [1:0]  flt;
    logic [2:0]  rs;
    logic [10:0] strb;
  } obs_t;

  typedef struct packed {
    logic       rst, ld, iv;
    logic [5:0] op;
    logic       rg;
    logic [3:0] fl;
    logic       ad, mr;
  } in_t;

  typedef struct packed {
    in_t  in;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic in_t mk(logic r, logic ld, logic iv, logic [5:0] op, logic rg,
                             logic [3:0] fl, logic ad, logic mr);
    return {r, ld, iv, op, rg, fl, ad, mr};
  endfunction

  function automatic obs_t ex(logic [3:0] st, logic [10:0] strb, logic [2:0] rs,
                              logic [1:0] flt, logic hlt);
    return {st, hlt, flt, rs, strb};
  endfunction

  function automatic obs_t sample();
    return {state, halted, fault, reg_signal,
            {read_file, read_memory, start_alu, mem_read, mem_write,
             lda, sta, inc_pc, jump, push, pop}};
  endfunction

  task automatic add(input in_t i, input obs_t e);
    vecs.push_back({i, e});
  endtask

  task automatic apply(input in_t v);
    rst = v.rst; load_done = v.ld; instr_valid = v.iv; opcode = v.op;
    register = v.rg; flags = v.fl; alu_done = v.ad; mem_ready = v.mr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st=%0d hlt=%b flt=%b rs=%b strb=%b, want st=%0d hlt=%b flt=%b rs=%b strb=%b",
                  name, act.st, act.hlt, act.flt, act.rs, act.strb,
                  exp.st, exp.hlt, exp.flt, exp.rs, exp.strb);
  endtask

  in_t idle;

  initial begin
    idle = mk(0, 0, 0, 6'h00, 0, 4'h0, 0, 0);
    rst = 1'b1; load_done = 1'b0; instr_valid = 1'b0; opcode = '0;
    register = 1'b0; flags = '0; alu_done = 1'b0; mem_ready = 1'b0;

    // Reset, then load_done on the third cycle.
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(idle,                              ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(idle,                              ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0), ex(FETCH, RM, 3'b000, 2'b00, 0));
    // ADD on X; stray alu_done in DECODE ignored; alu_done two cycles late.
    add(mk(0, 0, 1, 6'h0C, 1, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h0, 1, 0), ex(ASTART, SA, 3'b100, 2'b00, 0));
    add(idle,                              ex(AWAIT, NO, 3'b100, 2'b00, 0));
    add(idle,                              ex(AWAIT, NO, 3'b100, 2'b00, 0));
    add(idle,                              ex(AWAIT, NO, 3'b100, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h0, 1, 0), ex(COMMIT, IP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    // BRZ taken, BRZ not taken, BRC taken.
    add(mk(0, 0, 1, 6'h05, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h8, 0, 0), ex(BRANCH, JP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h05, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BRANCH, IP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h07, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h1, 0, 0), ex(BRANCH, JP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    // STA with mem_ready three cycles late.
    add(mk(0, 0, 1, 6'h03, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(MEM, MW | SS, 3'b001, 2'b00, 0));
    add(idle,                              ex(MEM, MW | SS, 3'b001, 2'b00, 0));
    add(idle,                              ex(MEM, MW | SS, 3'b001, 2'b00, 0));
    add(idle,                              ex(MEM, MW | SS, 3'b001, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h0, 0, 1), ex(COMMIT, IP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    // LDR on Y with immediate mem_ready, then NOP.
    add(mk(0, 0, 1, 6'h01, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(MEM, MR, 3'b010, 2'b00, 0));
    add(mk(0, 0, 0, 6'h00, 0, 4'h0, 0, 1), ex(COMMIT, IP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h00, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(COMMIT, IP, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    // JMP x3 with depth 2: third overflows.
    add(mk(0, 0, 1, 6'h0A, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, JP | PU, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h0A, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, JP | PU, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h0A, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(HALT, NO, 3'b000, 2'b10, 1));
    add(mk(0, 1, 1, 6'h0C, 1, 4'hF, 1, 1), ex(HALT, NO, 3'b000, 2'b10, 1));
    // RET from reset underflows.
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0), ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h0B, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(HALT, NO, 3'b000, 2'b10, 1));
    // JMP then RET: balanced push/pop.
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0), ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h0A, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, JP | PU, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h0B, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(BRANCH, JP | PO, 3'b000, 2'b00, 0));
    add(idle,                              ex(FETCH, RM, 3'b000, 2'b00, 0));
    // Illegal 0x1F, then activity on every input is ignored.
    add(mk(0, 0, 1, 6'h1F, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(HALT, NO, 3'b000, 2'b01, 1));
    add(mk(0, 1, 1, 6'h0C, 1, 4'hF, 1, 1), ex(HALT, NO, 3'b000, 2'b01, 1));
    add(mk(0, 1, 1, 6'h01, 0, 4'h0, 1, 1), ex(HALT, NO, 3'b000, 2'b01, 1));
    // Illegal 0x20.
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0), ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h20, 0, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(HALT, NO, 3'b000, 2'b01, 1));
    // LDA interrupted by reset mid-access.
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0), ex(BOOT, RF, 3'b000, 2'b00, 0));
    add(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0), ex(FETCH, RM, 3'b000, 2'b00, 0));
    add(mk(0, 0, 1, 6'h04, 1, 4'h0, 0, 0), ex(DECODE, NO, 3'b000, 2'b00, 0));
    add(idle,                              ex(MEM, MR | LD, 3'b001, 2'b00, 0));
    add(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 1), ex(BOOT, RF, 3'b000, 2'b00, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Watchdog expiry: 16 ALU_WAIT cycles without alu_done.
    apply(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0));
    check("to_fetch", ex(FETCH, RM, 3'b000, 2'b00, 0));
    apply(mk(0, 0, 1, 6'h1D, 0, 4'h0, 0, 0));
    check("to_decode", ex(DECODE, NO, 3'b000, 2'b00, 0));
    apply(idle);
    check("to_start", ex(ASTART, SA, 3'b010, 2'b00, 0));
    for (int k = 1; k <= 16; k++) begin
      apply(idle);
      check($sformatf("to_wait%0d", k), ex(AWAIT, NO, 3'b010, 2'b00, 0));
    end
    apply(idle);
    check("to_halt", ex(HALT, NO, 3'b000, 2'b11, 1));
    apply(mk(0, 0, 0, 6'h00, 0, 4'h0, 1, 0));
    check("to_halt_hold", ex(HALT, NO, 3'b000, 2'b11, 1));
    apply(mk(1, 0, 0, 6'h00, 0, 4'h0, 0, 0));
    check("to_reset", ex(BOOT, RF, 3'b000, 2'b00, 0));

    // alu_done on the 16th ALU_WAIT cycle beats the watchdog.
    apply(mk(0, 1, 0, 6'h00, 0, 4'h0, 0, 0));
    check("win_fetch", ex(FETCH, RM, 3'b000, 2'b00, 0));
    apply(mk(0, 0, 1, 6'h0C, 1, 4'h0, 0, 0));
    check("win_decode", ex(DECODE, NO, 3'b000, 2'b00, 0));
    apply(idle);
    check("win_start", ex(ASTART, SA, 3'b100, 2'b00, 0));
    for (int k = 1; k <= 16; k++) begin
      apply(idle);
      check($sformatf("win_wait%0d", k), ex(AWAIT, NO, 3'b100, 2'b00, 0));
    end
    apply(mk(0, 0, 0, 6'h00, 0, 4'h0, 1, 0));
    check("win_commit", ex(COMMIT, IP, 3'b000, 2'b00, 0));
    apply(idle);
    check("win_fetch2", ex(FETCH, RM, 3'b000, 2'b00, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
